// File: rtl/ex_if.sv
// Execute-stage data bundle: decoded operands from ID/EX and results towards EX/MEM.
interface ex_if;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        whilo_o;

  modport slave (
    input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
    output wd_o, wreg_o, wdata_o, hi_o, lo_o, whilo_o
  );

  modport master (
    output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
    input  wd_o, wreg_o, wdata_o, hi_o, lo_o, whilo_o
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: combinational logic/shift results plus an iterative 32x32
// MULT/MULTU unit that stalls the front of the pipeline until HI/LO are ready.
module ex_stage #(
  parameter int MUL_STEP = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  ex_if.slave  bus,
  output logic stallreq_o
);

  localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;

  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

  localparam int N  = 32 / MUL_STEP;
  localparam int SH = $clog2(MUL_STEP);
  localparam int CW = 6;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_reg;
  logic [CW-1:0] count_reg;
  logic [31:0]   mcand_reg;
  logic [31:0]   mplier_reg;
  logic          neg_reg;
  logic [63:0]   acc_reg;

  logic [31:0] alu_res;
  logic        is_signed;
  logic        is_mult;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [63:0] term [MUL_STEP];
  logic [63:0] step_sum;
  logic [7:0]  acc_shift;
  logic [63:0] acc_next;
  logic [63:0] product_next;
  logic        last_step;

  // Logic and shift result; shifts only honour reg1[4:0].
  always_comb begin
    alu_res = 32'h0;
    case (bus.alusel_i)
      EXE_RES_LOGIC: begin
        case (bus.aluop_i)
          EXE_OR_OP:  alu_res = bus.reg1_i | bus.reg2_i;
          EXE_AND_OP: alu_res = bus.reg1_i & bus.reg2_i;
          EXE_XOR_OP: alu_res = bus.reg1_i ^ bus.reg2_i;
          EXE_NOR_OP: alu_res = ~(bus.reg1_i | bus.reg2_i);
          default:    alu_res = 32'h0;
        endcase
      end
      EXE_RES_SHIFT: begin
        case (bus.aluop_i)
          EXE_SLL_OP: alu_res = bus.reg2_i << bus.reg1_i[4:0];
          EXE_SRL_OP: alu_res = bus.reg2_i >> bus.reg1_i[4:0];
          EXE_SRA_OP: alu_res = $signed(bus.reg2_i) >>> bus.reg1_i[4:0];
          default:    alu_res = 32'h0;
        endcase
      end
      EXE_RES_NOP: alu_res = 32'h0;
      default:     alu_res = 32'h0;
    endcase
  end

  assign is_signed = (bus.aluop_i == EXE_MULT_OP);
  assign is_mult   = is_signed || (bus.aluop_i == EXE_MULTU_OP);

  // Magnitude of 0x8000_0000 is 0x8000_0000 read as unsigned, so no 33rd bit is needed.
  assign abs_a = (is_signed && bus.reg1_i[31]) ? (~bus.reg1_i + 32'd1) : bus.reg1_i;
  assign abs_b = (is_signed && bus.reg2_i[31]) ? (~bus.reg2_i + 32'd1) : bus.reg2_i;

  genvar gi;
  generate
    for (gi = 0; gi < MUL_STEP; gi++) begin : g_term
      assign term[gi] = mplier_reg[gi] ? ({32'h0, mcand_reg} << gi) : 64'h0;
    end
  endgenerate

  always_comb begin
    step_sum = 64'h0;
    for (int k = 0; k < MUL_STEP; k++) begin
      step_sum = step_sum + term[k];
    end
  end

  assign acc_shift    = 8'(count_reg) << SH;
  assign acc_next     = acc_reg + (step_sum << acc_shift);
  assign product_next = neg_reg ? (~acc_next + 64'd1) : acc_next;
  assign last_step    = (count_reg == CW'(N - 1));

  // Multiplier consumes its low MUL_STEP bits each cycle and shifts right.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      neg_reg    <= 1'b0;
      acc_reg    <= '0;
    end else if (flush_i) begin
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (is_mult) begin
            mcand_reg  <= abs_a;
            mplier_reg <= abs_b;
            neg_reg    <= is_signed && (bus.reg1_i[31] ^ bus.reg2_i[31]);
            count_reg  <= '0;
            acc_reg    <= '0;
            state_reg  <= BUSY;
          end
        end
        BUSY: begin
          mplier_reg <= mplier_reg >> MUL_STEP;
          count_reg  <= count_reg + 1'b1;
          if (last_step) begin
            acc_reg   <= product_next;
            state_reg <= DONE;
          end else begin
            acc_reg <= acc_next;
          end
        end
        DONE: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // The MULT is still presented during DONE; returning to IDLE first prevents a restart.
  assign bus.whilo_o = !rst && !flush_i && (state_reg == DONE);
  assign bus.hi_o    = bus.whilo_o ? acc_reg[63:32] : 32'h0;
  assign bus.lo_o    = bus.whilo_o ? acc_reg[31:0]  : 32'h0;
  assign stallreq_o  = !rst && !flush_i &&
                       ((state_reg == BUSY) || ((state_reg == IDLE) && is_mult));

  assign bus.wd_o    = rst ? 5'h0  : bus.wd_i;
  assign bus.wreg_o  = rst ? 1'b0  : bus.wreg_i;
  assign bus.wdata_o = rst ? 32'h0 : alu_res;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: one DUT at MUL_STEP=1 and one at MUL_STEP=4,
// stimulus pushes expectations, per-instance monitors pop and compare.
module tb_ex_stage;

  localparam logic [7:0] OP_NOP   = 8'b0000_0000;
  localparam logic [7:0] OP_AND   = 8'b0010_0100;
  localparam logic [7:0] OP_OR    = 8'b0010_0101;
  localparam logic [7:0] OP_XOR   = 8'b0010_0110;
  localparam logic [7:0] OP_NOR   = 8'b0010_0111;
  localparam logic [7:0] OP_SLL   = 8'b0111_1100;
  localparam logic [7:0] OP_SRL   = 8'b0000_0010;
  localparam logic [7:0] OP_SRA   = 8'b0000_0011;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;

  typedef struct {
    logic [31:0] wdata;
    logic [4:0]  wd;
    logic        wreg;
    logic        stall;
  } alu_exp_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          stall;
  } mul_exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  aluop  [2];
  logic [2:0]  alusel [2];
  logic [31:0] reg1   [2];
  logic [31:0] reg2   [2];
  logic [4:0]  wd     [2];
  logic        wreg   [2];
  logic        flush  [2];
  logic        alu_chk[2];
  logic        whilo_w[2];

  alu_exp_t alu_q[2][$];
  mul_exp_t mul_q[2][$];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int inst, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL inst%0d %s: got %h want %h", inst, name, act, exp);
    end
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      localparam int STEP = (gi == 0) ? 1 : 4;
      ex_if bus ();
      logic stall;
      alu_exp_t ae;
      mul_exp_t me;
      int run = 0;

      assign bus.aluop_i  = aluop[gi];
      assign bus.alusel_i = alusel[gi];
      assign bus.reg1_i   = reg1[gi];
      assign bus.reg2_i   = reg2[gi];
      assign bus.wd_i     = wd[gi];
      assign bus.wreg_i   = wreg[gi];
      assign whilo_w[gi]  = bus.whilo_o;

      ex_stage #(.MUL_STEP(STEP)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (flush[gi]),
        .bus       (bus),
        .stallreq_o(stall)
      );

      always @(negedge clk) begin
        if (alu_chk[gi]) begin
          if (alu_q[gi].size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL inst%0d alu_q_underflow: got empty want entry", gi);
          end else begin
            ae = alu_q[gi].pop_front();
            $display("inst%0d alu wdata=%h wd=%0d wreg=%0b stall=%0b",
                     gi, bus.wdata_o, bus.wd_o, bus.wreg_o, stall);
            check("wdata", gi, 64'(bus.wdata_o), 64'(ae.wdata));
            check("wd", gi, 64'(bus.wd_o), 64'(ae.wd));
            check("wreg", gi, 64'(bus.wreg_o), 64'(ae.wreg));
            check("stallreq", gi, 64'(stall), 64'(ae.stall));
            check("whilo_quiet", gi, 64'(bus.whilo_o), 64'(0));
          end
        end
        if (bus.whilo_o) begin
          if (mul_q[gi].size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL inst%0d unexpected_whilo: got 1 want 0", gi);
          end else begin
            me = mul_q[gi].pop_front();
            $display("inst%0d mul hi=%h lo=%h stall_cycles=%0d", gi, bus.hi_o, bus.lo_o, run);
            check("hi", gi, 64'(bus.hi_o), 64'(me.hi));
            check("lo", gi, 64'(bus.lo_o), 64'(me.lo));
            check("stall_cycles", gi, 64'(run), 64'(me.stall));
            check("stall_in_done", gi, 64'(stall), 64'(0));
          end
        end
        if (rst || !stall) run = 0;
        else run = run + 1;
      end
    end
  endgenerate

  task automatic set_in(input int i, input logic [7:0] op, input logic [2:0] sel,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input logic w);
    aluop[i]  = op;
    alusel[i] = sel;
    reg1[i]   = a;
    reg2[i]   = b;
    wd[i]     = d;
    wreg[i]   = w;
  endtask

  // One cycle of inputs with an expected pass-through/ALU response.
  task automatic alu(input int i, input logic [7:0] op, input logic [2:0] sel,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] d, input logic w,
                     input logic [31:0] e_data, input logic [4:0] e_wd,
                     input logic e_wreg, input logic e_stall);
    alu_exp_t e;
    e.wdata = e_data;
    e.wd    = e_wd;
    e.wreg  = e_wreg;
    e.stall = e_stall;
    set_in(i, op, sel, a, b, d, w);
    alu_q[i].push_back(e);
    alu_chk[i] = 1'b1;
    @(posedge clk);
    #1;
    alu_chk[i] = 1'b0;
  endtask

  // Hold a multiply on the inputs until the DONE cycle, as a stalled ID would.
  task automatic mul(input int i, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] e_hi, input logic [31:0] e_lo);
    mul_exp_t e;
    bit seen;
    e.hi    = e_hi;
    e.lo    = e_lo;
    e.stall = (i == 0) ? 33 : 9;
    mul_q[i].push_back(e);
    set_in(i, sgn ? OP_MULT : OP_MULTU, SEL_NOP, a, b, 5'd0, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (whilo_w[i]) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL inst%0d mul_timeout: got no whilo want whilo within 100 cycles", i);
      void'(mul_q[i].pop_back());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input int i);
    set_in(i, OP_NOP, SEL_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      nop(i);
      flush[i]   = 1'b0;
      alu_chk[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    // Outputs forced to zero while reset is held, even with live inputs.
    alu(0, OP_OR, SEL_LOGIC, 32'h0000_F0F0, 32'h1234_0000, 5'd3, 1'b1, 32'h0, 5'd0, 1'b0, 1'b0);
    rst = 1'b0;

    alu(0, OP_OR,  SEL_LOGIC, 32'h0000_F0F0, 32'h1234_0000, 5'd3,  1'b1, 32'h1234_F0F0, 5'd3,  1'b1, 1'b0);
    alu(0, OP_AND, SEL_LOGIC, 32'hF0F0_FF00, 32'h0FF0_F0F0, 5'd4,  1'b1, 32'h00F0_F000, 5'd4,  1'b1, 1'b0);
    alu(0, OP_XOR, SEL_LOGIC, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd5,  1'b0, 32'hF0F0_0F0F, 5'd5,  1'b0, 1'b0);
    alu(0, OP_NOR, SEL_LOGIC, 32'h0000_00FF, 32'h0000_FF00, 5'd31, 1'b1, 32'hFFFF_0000, 5'd31, 1'b1, 1'b0);
    alu(0, OP_SRA, SEL_SHIFT, 32'h0000_0004, 32'h8000_0010, 5'd6,  1'b1, 32'hF800_0001, 5'd6,  1'b1, 1'b0);
    alu(0, OP_SRL, SEL_SHIFT, 32'h0000_0004, 32'h8000_0010, 5'd6,  1'b1, 32'h0800_0001, 5'd6,  1'b1, 1'b0);
    alu(0, OP_SLL, SEL_SHIFT, 32'h0000_0021, 32'h0000_0003, 5'd7,  1'b1, 32'h0000_0006, 5'd7,  1'b1, 1'b0);
    alu(0, OP_SRA, SEL_SHIFT, 32'hFFFF_FFE8, 32'h7000_0000, 5'd8,  1'b1, 32'h0070_0000, 5'd8,  1'b1, 1'b0);
    alu(0, 8'hFF,  SEL_LOGIC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9,  1'b1, 32'h0000_0000, 5'd9,  1'b1, 1'b0);
    alu(0, OP_OR,  SEL_NOP,   32'hFFFF_FFFF, 32'h1234_5678, 5'd10, 1'b1, 32'h0000_0000, 5'd10, 1'b1, 1'b0);

    mul(0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    mul(0, 1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    mul(0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    nop(0);
    @(posedge clk);
    #1;
    mul(0, 1'b1, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9);
    mul(0, 1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780);
    mul(0, 1'b1, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000);
    nop(0);
    @(posedge clk);
    #1;

    // Flush ten cycles into a multiply: stall drops, HI/LO never written.
    set_in(0, OP_MULT, SEL_NOP, 32'h0000_0100, 32'h0000_0200, 5'd0, 1'b0);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    flush[0] = 1'b1;
    alu(0, OP_NOP, SEL_NOP, 32'h0, 32'h0, 5'd2, 1'b1, 32'h0, 5'd2, 1'b1, 1'b0);
    flush[0] = 1'b0;
    alu(0, OP_NOP, SEL_NOP, 32'h0, 32'h0, 5'd2, 1'b1, 32'h0, 5'd2, 1'b1, 1'b0);
    mul(0, 1'b1, 32'h0000_0006, 32'h0000_0007, 32'h0000_0000, 32'h0000_002A);
    nop(0);
    @(posedge clk);
    #1;

    // Reset five cycles into a multiply: outputs zero, then back in IDLE.
    set_in(0, OP_MULTU, SEL_NOP, 32'hDEAD_BEEF, 32'h0000_1234, 5'd0, 1'b0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    alu(0, OP_OR, SEL_LOGIC, 32'h1, 32'h2, 5'd7, 1'b1, 32'h0, 5'd0, 1'b0, 1'b0);
    alu(0, OP_OR, SEL_LOGIC, 32'h1, 32'h2, 5'd7, 1'b1, 32'h0, 5'd0, 1'b0, 1'b0);
    rst = 1'b0;
    alu(0, OP_OR, SEL_LOGIC, 32'h1, 32'h2, 5'd7, 1'b1, 32'h3, 5'd7, 1'b1, 1'b0);
    mul(0, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);
    nop(0);

    mul(1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    mul(1, 1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    mul(1, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    mul(1, 1'b1, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9);
    nop(1);

    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("alu_q_leftover", i, 64'(alu_q[i].size()), 64'(0));
      check("mul_q_leftover", i, 64'(mul_q[i].size()), 64'(0));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
